// File: rtl/uart_fifo_pkg.sv
// Shared constants and level-update encoding for the UART TX/RX FIFOs.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: default data/address widths, default almost-full/almost-empty
// thresholds, and the level-update opcode plus the helper that derives it
// from the accepted read/write strobes.
package uart_fifo_pkg;

  localparam int unsigned UART_FIFO_DATA_W    = 8;
  localparam int unsigned UART_FIFO_ADDR_W    = 5;
  localparam int unsigned UART_FIFO_AFULL_TH  = 28;
  localparam int unsigned UART_FIFO_AEMPTY_TH = 2;

  // How the occupancy counter moves on a given edge.
  typedef enum logic [1:0] {
    LVL_HOLD = 2'd0,
    LVL_INC  = 2'd1,
    LVL_DEC  = 2'd2
  } lvl_op_e;

  // A simultaneous accepted push and pop leaves the level unchanged.
  function automatic lvl_op_e lvl_op(input logic wr_acc, input logic rd_acc);
    lvl_op_e op;
    op = LVL_HOLD;
    if (wr_acc && !rd_acc) op = LVL_INC;
    if (rd_acc && !wr_acc) op = LVL_DEC;
    return op;
  endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// Storage array for uart_sync_fifo: synchronous write, asynchronous read.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the caller guarantees a write only to a free slot.
//
// Ports:
//   clk            clock
//   we/waddr/wdata synchronous write port
//   raddr/rdata    asynchronous (combinational) read port
module uart_fifo_ram
  import uart_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = UART_FIFO_DATA_W,
  parameter int unsigned ADDR_W = UART_FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  // Contents are deliberately not reset so this maps onto LUT-RAM / latch arrays.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_sync_fifo.sv
// Parametrised synchronous FIFO for the UART TX/RX paths, registered or FWFT read.
// Latency: FWFT=0 read data one cycle after an accepted rd; FWFT=1 head word visible
// the cycle after it is written. Backpressure: writes refused when full unless a pop
// happens in the same cycle; reads refused when empty.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clr             synchronous flush (priority over wr/rd)
//   wr, wrdata      push request and data
//   rd              pop request
//   rddata,rd_valid read data and its qualifier
//   empty, full, almost_full, almost_empty, level   occupancy status
//   overflow, underflow                             sticky error flags
//
// Build option: define UART_FIFO_ERR_STAT_EN to implement the sticky
// overflow/underflow flags; otherwise both outputs are constant 0.
module uart_sync_fifo
  import uart_fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = UART_FIFO_DATA_W,
  parameter int unsigned ADDR_W    = UART_FIFO_ADDR_W,
  parameter int unsigned AFULL_TH  = UART_FIFO_AFULL_TH,
  parameter int unsigned AEMPTY_TH = UART_FIFO_AEMPTY_TH,
  parameter int unsigned FWFT      = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr,
  input  logic [DATA_W-1:0] wrdata,
  input  logic              rd,
  output logic [DATA_W-1:0] rddata,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned     DEPTH      = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_LVL   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_LVL  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AEMPTY_LVL = (ADDR_W+1)'(AEMPTY_TH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level_q;
  logic              rd_acc;
  logic              wr_acc;
  logic [DATA_W-1:0] ram_rdata;

  // ---------------------------------------------------------------------------
  // Status decode from the registered level
  // ---------------------------------------------------------------------------
  assign level        = level_q;
  assign empty        = (level_q == '0);
  assign full         = (level_q == FULL_LVL);
  assign almost_full  = (level_q >= AFULL_LVL);
  assign almost_empty = (level_q <= AEMPTY_LVL);

  // A write into a full FIFO is safe when the same edge frees the head slot.
  assign rd_acc = rd && !empty;
  assign wr_acc = wr && (!full || rd_acc);

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  uart_fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc && !clr),
    .waddr (wr_ptr),
    .wdata (wrdata),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  // ---------------------------------------------------------------------------
  // Pointers and level
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      // Pointers are exactly ADDR_W bits so DEPTH-1 wraps to 0 for free.
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case (lvl_op(wr_acc, rd_acc))
        LVL_INC: level_q <= level_q + 1'b1;
        LVL_DEC: level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------------
  if (FWFT != 0) begin : g_fwft
    // Head word is presented straight from the array; masked to 0 while empty
    // so stale or uninitialised contents never leak out.
    assign rddata   = empty ? '0 : ram_rdata;
    assign rd_valid = !empty;
  end else begin : g_reg
    logic [DATA_W-1:0] rddata_q;
    logic              rd_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rddata_q   <= '0;
        rd_valid_q <= 1'b0;
      end else if (clr) begin
        rddata_q   <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        // rd_valid is a one-cycle pulse; rddata holds until the next pop.
        rd_valid_q <= rd_acc;
        if (rd_acc) rddata_q <= ram_rdata;
      end
    end

    assign rddata   = rddata_q;
    assign rd_valid = rd_valid_q;
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------------
`ifdef UART_FIFO_ERR_STAT_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (clr) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr && !wr_acc) overflow_q  <= 1'b1;
      if (rd && empty)   underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Self-checking bench for uart_sync_fifo (registered-read and FWFT instances).
// Latency: registered-read data expected the cycle after an accepted pop.
// Backpressure: stimulus respects nothing; refused pushes/pops are part of the checks.
module tb_uart_sync_fifo;

`ifdef UART_FIFO_ERR_STAT_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       wr;
  logic [7:0] wrdata;
  logic       rd;
  logic [7:0] rddata;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic       almost_empty;
  logic [5:0] level;
  logic       overflow;
  logic       underflow;

  logic       f_clr;
  logic       f_wr;
  logic [7:0] f_wrdata;
  logic       f_rd;
  logic [7:0] f_rddata;
  logic       f_rd_valid;
  logic       f_empty;
  logic       f_full;
  logic       f_almost_full;
  logic       f_almost_empty;
  logic [5:0] f_level;
  logic       f_overflow;
  logic       f_underflow;

  int n_chk;
  int n_fail;

  logic [7:0] mdl[$];    // contents the registered-read FIFO should hold
  logic [7:0] exp_q[$];  // read data still owed by the registered-read FIFO

  uart_sync_fifo #(.FWFT(0)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .wr           (wr),
    .wrdata       (wrdata),
    .rd           (rd),
    .rddata       (rddata),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  uart_sync_fifo #(.FWFT(1)) u_dut_fwft (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (f_clr),
    .wr           (f_wr),
    .wrdata       (f_wrdata),
    .rd           (f_rd),
    .rddata       (f_rddata),
    .rd_valid     (f_rd_valid),
    .empty        (f_empty),
    .full         (f_full),
    .almost_full  (f_almost_full),
    .almost_empty (f_almost_empty),
    .level        (f_level),
    .overflow     (f_overflow),
    .underflow    (f_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endfunction

  // Monitor: every rd_valid cycle must match the oldest owed word.
  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rd_valid_unexpected: actual data %0h required no read", rddata);
      end else begin
        chk("rddata", {24'h0, rddata}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // One clock of stimulus on the registered-read instance; the queue model
  // decides acceptance from the pre-edge occupancy.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r);
    logic r_acc;
    logic w_acc;
    r_acc = r && (mdl.size() != 0);
    w_acc = w && ((mdl.size() < 32) || r_acc);
    if (r_acc) exp_q.push_back(mdl.pop_front());
    if (w_acc) mdl.push_back(d);
    wr = w; wrdata = d; rd = r;
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic flush(input logic w, input logic r);
    clr = 1'b1; wr = w; rd = r; wrdata = 8'hFF;
    mdl.delete();
    @(posedge clk); #1;
    clr = 1'b0; wr = 1'b0; rd = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; clr = 1'b0; wr = 1'b0; rd = 1'b0; wrdata = '0;
    f_clr = 1'b0; f_wr = 1'b0; f_rd = 1'b0; f_wrdata = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rddata", rddata, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_fwft_valid", f_rd_valid, 0);
    rst_n = 1'b1;

    // FWFT: head word visible without a pop
    f_wr = 1'b1; f_wrdata = 8'hA5;
    chk("fwft_pre_valid", f_rd_valid, 0);
    @(posedge clk); #1;
    f_wr = 1'b0;
    chk("fwft_valid", f_rd_valid, 1);
    chk("fwft_data", f_rddata, 8'hA5);
    chk("fwft_empty", f_empty, 0);
    f_wr = 1'b1; f_wrdata = 8'h5A; f_rd = 1'b1;
    @(posedge clk); #1;
    f_wr = 1'b0; f_rd = 1'b0;
    chk("fwft_next_data", f_rddata, 8'h5A);
    chk("fwft_next_level", f_level, 1);
    f_rd = 1'b1;
    @(posedge clk); #1;
    f_rd = 1'b0;
    chk("fwft_pop_empty", f_empty, 1);
    chk("fwft_pop_valid", f_rd_valid, 0);

    // Fill / drain
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1, 8'(i), 1'b0);
      if (i == 1)  chk("fill_aempty_at2", almost_empty, 1);
      if (i == 2)  chk("fill_aempty_at3", almost_empty, 0);
      if (i == 26) chk("fill_afull_at27", almost_full, 0);
      if (i == 27) chk("fill_afull_at28", almost_full, 1);
      if (i == 30) chk("fill_full_at31", full, 0);
    end
    chk("fill_full", full, 1);
    chk("fill_level", level, 32);
    for (int i = 0; i < 32; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    chk("drain_empty", empty, 1);
    chk("drain_level", level, 0);
    chk("drain_valid_pulse", rd_valid, 0);
    chk("drain_hold_data", rddata, 8'h1F);

    // Pointer wrap
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0);
    chk("wrap_level20", level, 20);
    for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    chk("wrap_level0", level, 0);

    // Simultaneous push and pop at level 5
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
    cycle(1'b1, 8'hD0, 1'b1);
    chk("rdwr_mid_level", level, 5);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1);

    // Simultaneous push and pop at full
    for (int i = 0; i < 32; i++) cycle(1'b1, 8'(8'h90 + i), 1'b0);
    cycle(1'b1, 8'hEE, 1'b1);
    chk("rdwr_full_level", level, 32);
    chk("rdwr_full_flag", full, 1);
    chk("rdwr_full_overflow", overflow, 0);
    for (int i = 0; i < 32; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    chk("rdwr_full_last", rddata, 8'hEE);

    // Simultaneous push and pop at empty: pop refused
    cycle(1'b1, 8'h77, 1'b1);
    chk("rdwr_empty_level", level, 1);
    chk("rdwr_empty_underflow", underflow, ERR_EN);
    cycle(1'b0, 8'h00, 1'b0);
    chk("underflow_sticky", underflow, ERR_EN);

    // Flush beats a concurrent push and pop
    flush(1'b1, 1'b1);
    chk("clr_level", level, 0);
    chk("clr_empty", empty, 1);
    chk("clr_rddata", rddata, 0);
    chk("clr_rd_valid", rd_valid, 0);
    chk("clr_underflow", underflow, 0);

    // Overflow: push at full without a pop
    for (int i = 0; i < 32; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0);
    cycle(1'b1, 8'h99, 1'b0);
    chk("ovf_level", level, 32);
    chk("ovf_set", overflow, ERR_EN);
    cycle(1'b0, 8'h00, 1'b0);
    chk("ovf_sticky", overflow, ERR_EN);
    flush(1'b0, 1'b0);
    chk("ovf_clr_level", level, 0);
    chk("ovf_clr_flag", overflow, 0);

    // Asynchronous reset mid-burst
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0);
    chk("arst_pre_level", level, 10);
    rst_n = 1'b0;
    #1;
    chk("arst_level", level, 0);
    chk("arst_empty", empty, 1);
    mdl.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(1'b1, 8'h3C, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    chk("arst_after_data", rddata, 8'h3C);
    chk("arst_after_level", level, 0);

    cycle(1'b0, 8'h00, 1'b0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
